// File: rtl/qspi_cmd_sequencer.sv
// qspi_cmd_sequencer
//   Host-side command front end for qspi_mem_controller. The host writes a
//   header word (counts, payload length, quad select), then the payload
//   words. These are packed into the controller command vector and the
//   controller is triggered. After completion, any readout is streamed back
//   to the host as HOST_W words over a valid/ready handshake.
//
//   Optional feature (macro QSPI_ACK_TIMEOUT_EN): abort the trigger with a
//   sticky error when mc_busy is not seen within ACK_TIMEOUT cycles.
//
// Ports
//   clk_in, reset_n           clock, async active-low reset
//   wr, data_from_PC          host word strobe and word (header/payload)
//   busy, error               not ready for a header / sticky error
//   rd_valid, rd_ready,
//   rd_data, rd_last          readout stream to host, MS word first
//   mc_trigger, mc_quad,
//   mc_data_in_count,
//   mc_data_out_count,
//   mc_data_in                command to controller
//   mc_readout, mc_busy,
//   mc_error                  status/data from controller
module qspi_cmd_sequencer #(
  parameter int HOST_W      = 32,
  parameter int CNT_W       = 12,
  parameter int LEN_W       = 7,
  parameter int MAXCMD      = 8,
  parameter int RD_W        = 64,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic                        wr,
  input  logic [HOST_W-1:0]           data_from_PC,
  output logic                        busy,
  output logic                        error,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [HOST_W-1:0]           rd_data,
  output logic                        rd_last,
  output logic                        mc_trigger,
  output logic                        mc_quad,
  output logic [CNT_W-1:0]            mc_data_in_count,
  output logic [CNT_W-1:0]            mc_data_out_count,
  output logic [(3+MAXCMD)*8-1:0]     mc_data_in,
  input  logic [RD_W-1:0]             mc_readout,
  input  logic                        mc_busy,
  input  logic                        mc_error
);

  localparam int CMD_W = (3+MAXCMD)*8;
  localparam int NW    = RD_W / HOST_W;   // readout words per command
  localparam int WC_W  = $clog2(NW + 1);

  // Parameter sanity: header fields must fit below the quad bit, readout
  // must split into whole host words, timeout must be non-zero.
  if (2*CNT_W + LEN_W >= HOST_W) begin : g_bad_hdr
    $error("qspi_cmd_sequencer: header fields do not fit in HOST_W");
  end
  if (RD_W % HOST_W != 0) begin : g_bad_rd
    $error("qspi_cmd_sequencer: HOST_W must divide RD_W");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_to
    $error("qspi_cmd_sequencer: ACK_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACK, S_RUN, S_DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len;
  logic [RD_W-1:0]   rd_sr;    // readout words still to present, MS aligned
  logic [WC_W-1:0]   wleft;    // words remaining after the current rd_data

  logic hdr_take, rd_fire, ack_to;

  assign hdr_take = !busy && wr;
  assign rd_fire  = rd_valid && rd_ready;

`ifdef QSPI_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  assign ack_to = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
  assign ack_to = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hdr_take)               state_nxt = S_LOAD;
      S_LOAD:  if (len == '0)              state_nxt = S_ACK;
      S_ACK:   if (mc_busy)                state_nxt = S_RUN;
               else if (ack_to)            state_nxt = S_IDLE;
      S_RUN:   if (!mc_busy)               state_nxt = (mc_data_out_count == '0) ? S_IDLE : S_DRAIN;
      S_DRAIN: if (rd_fire && rd_last)     state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      busy              <= 1'b1;
      error             <= 1'b0;
      rd_valid          <= 1'b0;
      rd_last           <= 1'b0;
      rd_data           <= '0;
      rd_sr             <= '0;
      wleft             <= '0;
      mc_trigger        <= 1'b0;
      mc_quad           <= 1'b0;
      mc_data_in_count  <= '0;
      mc_data_out_count <= '0;
      mc_data_in        <= '0;
      len               <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          mc_trigger <= 1'b0;
          // Busy drops one IDLE cycle after the controller is quiet; the
          // header is only taken once busy has been seen low by the host.
          if (busy && !mc_busy) begin
            busy <= 1'b0;
          end else if (hdr_take) begin
            mc_data_in_count  <= data_from_PC[CNT_W-1:0];
            mc_data_out_count <= data_from_PC[2*CNT_W-1:CNT_W];
            len               <= data_from_PC[2*CNT_W +: LEN_W];
            mc_quad           <= data_from_PC[HOST_W-1];
            busy              <= 1'b1;
          end
        end
        S_LOAD: begin
          if (len == '0) begin
            mc_trigger <= 1'b1;
          end else if (wr) begin
            // Oldest bits fall off the top when the payload overflows.
            mc_data_in <= CMD_W'({mc_data_in, data_from_PC});
            len        <= len - LEN_W'(1);
          end
        end
        S_ACK: begin
          if (mc_busy) begin
            mc_trigger <= 1'b0;
          end else if (ack_to) begin
            mc_trigger <= 1'b0;
            error      <= 1'b1;
          end
        end
        S_RUN: begin
          if (!mc_busy) begin
            error <= error | mc_error;
            if (mc_data_out_count != '0) begin
              rd_data  <= mc_readout[RD_W-1 -: HOST_W];
              rd_sr    <= mc_readout << HOST_W;
              wleft    <= WC_W'(NW - 1);
              rd_valid <= 1'b1;
              rd_last  <= (NW == 1);
            end
          end
        end
        S_DRAIN: begin
          if (rd_fire) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end else begin
              rd_data <= rd_sr[RD_W-1 -: HOST_W];
              rd_sr   <= rd_sr << HOST_W;
              wleft   <= wleft - WC_W'(1);
              rd_last <= (wleft == WC_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef QSPI_ACK_TIMEOUT_EN
  // Counts cycles spent in ACK; restarted on every pass through LOAD.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)              to_cnt <= '0;
    else if (state == S_LOAD)  to_cnt <= '0;
    else if (state == S_ACK)   to_cnt <= to_cnt + TO_W'(1);
  end
`endif

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Randomised self-checking bench for qspi_cmd_sequencer. A transaction-level
// model keeps the expected command vector (shifted host words), the sticky
// error and the expected readout word sequence.
module tb_qspi_cmd_sequencer;
  localparam int HOST_W = 32, CNT_W = 12, LEN_W = 7, MAXCMD = 8, RD_W = 64;
  localparam int CMD_W  = (3+MAXCMD)*8;
  localparam int NW     = RD_W / HOST_W;
`ifdef QSPI_ACK_TIMEOUT_EN
  localparam int ATO = 15;
`else
  localparam int ATO = 1023;
`endif

  logic clk_in = 0, reset_n = 0, wr = 0, rd_ready = 0;
  logic mc_busy = 0, mc_error = 0;
  logic [HOST_W-1:0] data_from_PC = '0;
  logic [RD_W-1:0]   mc_readout = '0;
  logic busy, error, rd_valid, rd_last, mc_trigger, mc_quad;
  logic [HOST_W-1:0] rd_data;
  logic [CNT_W-1:0]  mc_data_in_count, mc_data_out_count;
  logic [CMD_W-1:0]  mc_data_in;

  qspi_cmd_sequencer #(.HOST_W(HOST_W), .CNT_W(CNT_W), .LEN_W(LEN_W),
    .MAXCMD(MAXCMD), .RD_W(RD_W), .ACK_TIMEOUT(ATO)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .wr(wr), .data_from_PC(data_from_PC),
    .busy(busy), .error(error), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .mc_trigger(mc_trigger),
    .mc_quad(mc_quad), .mc_data_in_count(mc_data_in_count),
    .mc_data_out_count(mc_data_out_count), .mc_data_in(mc_data_in),
    .mc_readout(mc_readout), .mc_busy(mc_busy), .mc_error(mc_error));

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_fail = 0;
  logic [CMD_W-1:0] m_din;   // model: command vector
  logic             m_err;   // model: sticky error

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_rdl"}, rd_last, 0);
    chk({tag, "_trig"}, mc_trigger, 0);
    chk({tag, "_quad"}, mc_quad, 0);
    chk({tag, "_cnts"}, {mc_data_in_count, mc_data_out_count}, 0);
    chk({tag, "_din"}, mc_data_in, 0);
    chk({tag, "_rdd"}, rd_data, 0);
  endtask

  // Assert reset asynchronously (mid-cycle), check, release, check busy drop.
  task automatic do_reset(input string tag);
    wr = 0; rd_ready = 0; mc_busy = 0; mc_error = 0;
    reset_n = 0;
    #1 chk_reset_vals(tag);
    @(negedge clk_in);
    chk_reset_vals({tag, "_hold"});
    reset_n = 1;
    m_din = '0; m_err = 0;
    @(negedge clk_in);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin @(negedge clk_in); n++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  // abort: 0 none, 1 reset while in ACK, 2 reset during DRAIN.
  task automatic run_cmd(input logic [CNT_W-1:0] in_c, input logic [CNT_W-1:0] out_c,
                         input logic quad, input logic [HOST_W-1:0] pl[$],
                         input logic [RD_W-1:0] rdv, input logic mcerr,
                         input bit toggle_rdy, input int abort);
    logic [HOST_W-1:0] hdr, expw;
    logic [RD_W-1:0]   sh;
    int n, i, cyc;
    bit tog;
    wait_idle("pre");
    hdr = '0;
    hdr[CNT_W-1:0]       = in_c;
    hdr[2*CNT_W-1:CNT_W] = out_c;
    hdr[2*CNT_W +: LEN_W] = LEN_W'(pl.size());
    hdr[HOST_W-1]        = quad;
    wr = 1; data_from_PC = hdr;
    @(negedge clk_in);
    chk("hdr_busy", busy, 1);
    if (pl.size() == 0) begin
      wr = 0;
      chk("len0_trig_early", mc_trigger, 0);
      @(negedge clk_in);
      chk("len0_trig", mc_trigger, 1);
    end
    foreach (pl[k]) begin
      repeat ($urandom % 3) begin
        wr = 0; data_from_PC = $urandom; @(negedge clk_in);
      end
      wr = 1; data_from_PC = pl[k];
      @(negedge clk_in);
      m_din = (m_din << HOST_W) | CMD_W'(pl[k]);
    end
    n = 0;
    while (!mc_trigger && n < 20) begin
      wr = 1'($urandom); data_from_PC = $urandom;
      @(negedge clk_in); n++;
    end
    chk("trig", mc_trigger, 1);
    chk("din", mc_data_in, m_din);
    chk("quad", mc_quad, quad);
    chk("in_cnt", mc_data_in_count, in_c);
    chk("out_cnt", mc_data_out_count, out_c);
    repeat ($urandom % 4) begin
      wr = 1'($urandom); @(negedge clk_in);
      chk("trig_hold", mc_trigger, 1);
    end
    if (abort == 1) begin
      do_reset("rst_ack");
      return;
    end
    mc_busy = 1;
    @(negedge clk_in);
    chk("trig_drop", mc_trigger, 0);
    mc_readout = rdv; mc_error = mcerr;
    repeat (1 + $urandom % 3) begin
      wr = 1'($urandom); data_from_PC = $urandom; @(negedge clk_in);
      chk("run_rdv", rd_valid, 0);
    end
    mc_busy = 0; wr = 0;
    @(negedge clk_in);
    mc_error = 0;
    m_err = m_err | mcerr;
    chk("err", error, m_err);
    chk("rdv_start", rd_valid, out_c != 0);
    if (out_c != 0) begin
      i = 0; cyc = 0; tog = 1;
      while (i < NW && cyc < 200) begin
        sh = rdv >> (RD_W - HOST_W*(i+1));
        expw = sh[HOST_W-1:0];
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, expw);
        chk("rd_last", rd_last, i == NW-1);
        if (abort == 2) begin
          do_reset("rst_drain");
          return;
        end
        rd_ready = toggle_rdy ? tog : 1'($urandom);
        tog = !tog;
        wr = 1'($urandom); data_from_PC = $urandom;
        @(negedge clk_in);
        if (rd_ready) i++;
        cyc++;
      end
      rd_ready = 0; wr = 0;
      chk("drain_words", i, NW);
      chk("rdv_end", rd_valid, 0);
    end
    wait_idle("post");
    chk("err_post", error, m_err);
  endtask

  task automatic rand_cmd(input logic mcerr, input int abort);
    logic [HOST_W-1:0] pl[$];
    int len = $urandom % 5;
    logic [CNT_W-1:0] oc = ($urandom % 4 == 0) ? '0 : CNT_W'($urandom);
    for (int k = 0; k < len; k++) pl.push_back($urandom);
    run_cmd(CNT_W'($urandom), oc, 1'($urandom), pl, {$urandom, $urandom},
            mcerr, 0, abort);
  endtask

  initial begin
    logic [HOST_W-1:0] pl[$];
    int n;
    m_din = '0; m_err = 0;
    @(negedge clk_in);
    do_reset("reset");

    // Directed example command with toggling ready.
    pl = '{32'h0B00_0000, 32'h1234_5678};
    run_cmd(12'd4, 12'd4, 1'b1, pl, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 0);
    chk("ex_din64", mc_data_in[63:0], 64'h0B00_0000_1234_5678);

    for (int t = 0; t < 15; t++) rand_cmd(0, 0);

    // Write-enable style command with controller error.
    pl = '{};
    run_cmd(12'd1, 12'd0, 1'b0, pl, '0, 1, 0, 0);
    chk("err_sticky", error, 1);

    for (int t = 0; t < 8; t++) rand_cmd(1'($urandom), 0);
    chk("err_still", error, 1);

    // Reset mid-operation, then a normal command.
    pl = '{32'hA5A5_0001};
    run_cmd(12'd2, 12'd8, 1'b1, pl, 64'h0102_0304_0506_0708, 0, 0, 2);
    rand_cmd(0, 1);
    pl = '{32'h0300_0000};
    run_cmd(12'd4, 12'd8, 1'b0, pl, 64'h1111_2222_3333_4444, 0, 1, 0);
    chk("err_after_rst", error, 0);

`ifdef QSPI_ACK_TIMEOUT_EN
    wait_idle("to_pre");
    wr = 1; data_from_PC = '0;
    @(negedge clk_in);
    wr = 0;
    @(negedge clk_in);
    chk("to_trig", mc_trigger, 1);
    n = 0;
    while (mc_trigger && n < 40) begin n++; @(negedge clk_in); end
    chk("to_cycles", n, ATO);
    chk("to_err", error, 1);
    wait_idle("to_post");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/qspi_cmd_sequencer.md
Name: qspi_cmd_sequencer

Overview:
- Parametrised host-side command front end for qspi_mem_controller; the next generation of the single-dword host interface.
- Accepts a header word plus payload words from the PC link and packs them into the controller command vector.
- Triggers the controller and waits for the acknowledge and completion.
- Unlike the fixed 32-bit predecessor, it generalises host word width, count widths and command depth. It also streams the controller readout back to the host as HOST_W words over a valid/ready handshake, with a sticky error report.

Parameters:
- HOST_W, 32: host word width; must satisfy 2*CNT_W+LEN_W < HOST_W and divide RD_W.
- CNT_W, 12: width of the data_in / data_out byte counts.
- LEN_W, 7: width of the payload word-count field.
- MAXCMD, 8: max command bytes; command vector width CMD_W = (3+MAXCMD)*8.
- RD_W, 64: controller readout width.
- ACK_TIMEOUT, 1023: cycles to wait for mc_busy after trigger (used only with the optional feature).

Ports:
- clk_in  in  1  system clock; controller clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr  in  1  host word strobe, one word per cycle.
- data_from_PC  in  HOST_W  host header/payload word.
- busy  out  1  block not ready for a new header.
- error  out  1  sticky error flag.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  host accepts readout word.
- rd_data  out  HOST_W  readout word.
- rd_last  out  1  final readout word of the command.
- mc_trigger  out  1  controller start.
- mc_quad  out  1  quad mode select.
- mc_data_in_count  out  CNT_W  to controller.
- mc_data_out_count  out  CNT_W  to controller.
- mc_data_in  out  CMD_W  packed command/address/data.
- mc_readout  in  RD_W  controller readout.
- mc_busy  in  1  controller busy.
- mc_error  in  1  controller error.

Behaviour:
- Reset (async, active-low):
  - state=IDLE, busy=1, error=0, rd_valid=0, rd_last=0, mc_trigger=0, mc_quad=0.
  - Counts, mc_data_in and rd_data clear to 0.
- Header layout:
  - [CNT_W-1:0] = in count.
  - [2*CNT_W-1:CNT_W] = out count.
  - [2*CNT_W+LEN_W-1:2*CNT_W] = len (payload words).
  - [HOST_W-1] = quad.
  - All other bits ignored.
- IDLE:
  - mc_trigger=0.
  - If busy=1 and mc_busy=0: busy<=0 and consume nothing this cycle.
  - Else if busy=0 and wr: latch the header, busy<=1, go to LOAD.
- LOAD:
  - On each wr with len>0: mc_data_in <= {mc_data_in[CMD_W-HOST_W-1:0], data_from_PC}, len<=len-1. The first word ends up most significant.
  - If more than CMD_W/HOST_W words arrive, the oldest bits are shifted out and lost. No error is raised.
  - When len==0: mc_trigger<=1, go to ACK. A header with len=0 reaches ACK two cycles after the header wr.
- ACK:
  - Hold mc_trigger=1 until mc_busy=1 is sampled.
  - Then mc_trigger<=0 and go to RUN.
- RUN:
  - Wait for mc_busy=0, then error <= error | mc_error.
  - If out count==0: go to IDLE; busy drops on the following IDLE cycle.
  - Else capture mc_readout into a shift register and go to DRAIN.
- DRAIN:
  - Present RD_W/HOST_W words, most significant first: rd_valid=1, rd_data = current word.
  - Advance on rd_valid&&rd_ready.
  - rd_last=1 on the final word. After its handshake: rd_valid<=0, go to IDLE.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
- Host-side rules:
  - wr while busy=1 outside LOAD is ignored.
  - wr during DRAIN is ignored.
- error clears only on reset.
- Reset mid-operation:
  - All outputs return to reset values asynchronously, including mc_trigger=0 and rd_valid=0 immediately.
  - Any partial command is discarded.

Optional Feature:
- Macro QSPI_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs in ACK.
  - If mc_busy is not seen within ACK_TIMEOUT cycles: mc_trigger<=0, error<=1, return to IDLE with no drain.
- Undefined: ACK waits indefinitely; ACK_TIMEOUT is unused and no counter is synthesised.

Test Plan:
- Reset with mc_busy=0: busy=1 during reset, busy=0 one cycle after reset_n rises; all other outputs 0.
- Header 0x8200_4004 (in=4, out=4, len=2, quad=1) then payload 0x0B00_0000 and 0x1234_5678 -> mc_data_in[63:0]=0x0B00_0000_1234_5678, mc_quad=1, mc_trigger held until mc_busy=1.
- After that command completes with mc_readout=0xDEAD_BEEF_CAFE_F00D and rd_ready toggling 1/0 -> words 0xDEADBEEF then 0xCAFEF00D; rd_data stable while stalled; rd_last on the 2nd word; busy=0 afterwards.
- Header with len=0 and out=0 (write-enable style) -> trigger two cycles after wr, no rd_valid, back to IDLE; mc_error=1 at completion -> error=1 and stays 1.
- reset_n pulsed low during DRAIN -> rd_valid=0 and mc_trigger=0 immediately; the next command works normally.
- With QSPI_ACK_TIMEOUT_EN and ACK_TIMEOUT=15, mc_busy tied 0 -> error=1 and mc_trigger=0 after 15 cycles in ACK; the block returns to IDLE.
